// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
//   Feeds the moore_1101 detector. W-bit words arrive on a valid/ready
//   handshake and go out on x_out one bit per clock. A one-word holding
//   register lets back-to-back words stream with no idle gap between them.
//   When no word is in flight, x_out sits at IDLE_BIT and x_vld is low.
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear; drops the held word and the word in flight
//   in_data    word to serialize (held stable while in_valid && !in_ready)
//   in_valid   in_data is valid
//   in_ready   holding register empty (straight from a flop)
//   x_out      serial bit to the detector (direct flop output)
//   x_vld      x_out carries a data bit this cycle
//   word_done  one-cycle pulse while the last bit of a word is on x_out
//   busy       shifting a word or holding one
module serial_bit_feeder #(
  parameter int   W         = 4,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         x_out,
  output logic         x_vld,
  output logic         word_done,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(W - 2);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e        state_q;
  logic [W-1:0]  hreg_q;
  logic          hvalid_q;
  logic [W-1:0]  sreg_q;
  logic [CW-1:0] cnt_q;
  logic          x_out_q;
  logic          x_vld_q;
  logic          word_done_q;

  logic          accept_d;
  logic          load_d;

  // Bit that leaves first when a word is loaded.
  function automatic logic first_bit(input logic [W-1:0] w);
    if (MSB_FIRST) begin
      first_bit = w[W-1];
    end else begin
      first_bit = w[0];
    end
  endfunction

  // Bit that follows the current one (read before the shift).
  function automatic logic next_bit(input logic [W-1:0] w);
    if (MSB_FIRST) begin
      next_bit = w[W-2];
    end else begin
      next_bit = w[1];
    end
  endfunction

  // Advance the shift register by one position in output order.
  function automatic logic [W-1:0] shift_word(input logic [W-1:0] w);
    if (MSB_FIRST) begin
      shift_word = {w[W-2:0], 1'b0};
    end else begin
      shift_word = {1'b0, w[W-1:1]};
    end
  endfunction

  // Handshake and load decisions; they are mutually exclusive because
  // accept needs an empty hold and load needs a full one.
  always_comb begin
    accept_d = in_valid && !hvalid_q && !flush;
    if (state_q == ST_IDLE) begin
      load_d = hvalid_q;
    end else begin
      load_d = hvalid_q && (cnt_q == CNT_LAST);
    end
  end

  // Holding register, shift register, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hreg_q      <= '0;
      hvalid_q    <= 1'b0;
      sreg_q      <= '0;
      cnt_q       <= '0;
      x_out_q     <= IDLE_BIT;
      x_vld_q     <= 1'b0;
      word_done_q <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      hvalid_q    <= 1'b0;
      cnt_q       <= '0;
      x_out_q     <= IDLE_BIT;
      x_vld_q     <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      if (accept_d) begin
        hreg_q   <= in_data;
        hvalid_q <= 1'b1;
      end else if (load_d) begin
        hvalid_q <= 1'b0;
      end else begin
        hvalid_q <= hvalid_q;
      end

      if (load_d) begin
        // Covers both a fresh start from IDLE and the gapless reload
        // on the last bit of the previous word.
        state_q     <= ST_SHIFT;
        sreg_q      <= hreg_q;
        cnt_q       <= '0;
        x_out_q     <= first_bit(hreg_q);
        x_vld_q     <= 1'b1;
        word_done_q <= 1'b0;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            if (cnt_q != CNT_LAST) begin
              sreg_q      <= shift_word(sreg_q);
              cnt_q       <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
              x_out_q     <= next_bit(sreg_q);
              x_vld_q     <= 1'b1;
              // Pulse lines up with the last bit reaching x_out.
              word_done_q <= (cnt_q == CNT_PEN);
            end else begin
              state_q     <= ST_IDLE;
              cnt_q       <= '0;
              x_out_q     <= IDLE_BIT;
              x_vld_q     <= 1'b0;
              word_done_q <= 1'b0;
            end
          end
          ST_IDLE: begin
            x_out_q     <= IDLE_BIT;
            x_vld_q     <= 1'b0;
            word_done_q <= 1'b0;
          end
          default: begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            x_out_q     <= IDLE_BIT;
            x_vld_q     <= 1'b0;
            word_done_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = !hvalid_q;
  assign busy      = (state_q == ST_SHIFT) || hvalid_q;
  assign x_out     = x_out_q;
  assign x_vld     = x_vld_q;
  assign word_done = word_done_q;

endmodule
